// File: rtl/l2_instruction_responder_pkg.sv
// Shared L1/L2 instruction-cache definitions: block geometry and responder FSM encodings.
package l2_instruction_responder_pkg;
    localparam int L2_DATA_WIDTH     = 32;
    localparam int L2_WORD_PER_BLOCK = 16;
    localparam int L2_BLOCK_WIDTH    = L2_WORD_PER_BLOCK * L2_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_RESPOND = 2'd2
    } l2_state_e;
endpackage

// File: rtl/l2_instruction_responder_block_assembly_register.sv
// Cache-block register filled one word at a time at a word index.
module block_assembly_register #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 16,
    parameter int IDX_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_we,
    input  logic [IDX_W-1:0]            i_idx,
    input  logic [DATA_WIDTH-1:0]       i_word,
    output logic [WORDS*DATA_WIDTH-1:0] o_block
);
    logic [WORDS*DATA_WIDTH-1:0] r_block;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_block <= '0;
        else if (i_we)
            r_block[i_idx*DATA_WIDTH +: DATA_WIDTH] <= i_word;
    end

    assign o_block = r_block;
endmodule

// File: rtl/l2_instruction_responder.sv
// Serves an L1 instruction-cache miss by reading a whole block word-by-word from backing store.
module l2_instruction_responder
    import l2_instruction_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = L2_DATA_WIDTH,
    parameter int WORD_PER_BLOCK = L2_WORD_PER_BLOCK
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    input  logic                                 ADDRESS_TO_L2_VALID_INS,
    output logic                                 ADDRESS_TO_L2_READY_INS,
    input  logic [ADDRESS_WIDTH-3:0]             ADDRESS_TO_L2_INS,
    output logic                                 DATA_FROM_L2_VALID_INS,
    input  logic                                 DATA_FROM_L2_READY_INS,
    output logic [WORD_PER_BLOCK*DATA_WIDTH-1:0] DATA_FROM_L2_INS,
    output logic                                 MEM_READ_VALID,
    input  logic                                 MEM_READ_READY,
    output logic [ADDRESS_WIDTH-3:0]             MEM_ADDRESS,
    input  logic                                 MEM_DATA_VALID,
    input  logic [DATA_WIDTH-1:0]                MEM_DATA
);
    localparam int BLOCK_WIDTH = WORD_PER_BLOCK * DATA_WIDTH;
    localparam int AW    = ADDRESS_WIDTH - 2;
    localparam int IDX_W = $clog2(WORD_PER_BLOCK);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WORD_PER_BLOCK);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORD_PER_BLOCK - 1);
    localparam logic [AW-1:0]    BASE_MASK = ~AW'(WORD_PER_BLOCK - 1);

    l2_state_e          r_state, w_next_state;
    logic [AW-1:0]      r_base;
    logic [CNT_W-1:0]   r_issue_cnt, r_recv_cnt;
    logic               r_ready, r_data_valid;
    logic               w_req_hs, w_rd_valid, w_rd_hs, w_wr, w_last;
    logic [BLOCK_WIDTH-1:0] w_block;

    // r_ready is only ever high in IDLE, so it alone qualifies the request handshake
    assign w_req_hs   = ADDRESS_TO_L2_VALID_INS && r_ready;
    assign w_rd_valid = (r_state == ST_FETCH) && (r_issue_cnt < CNT_FULL);
    assign w_rd_hs    = w_rd_valid && MEM_READ_READY;
    assign w_wr       = (r_state == ST_FETCH) && MEM_DATA_VALID && (r_recv_cnt < CNT_FULL);
    assign w_last     = w_wr && (r_recv_cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_ready      <= (w_next_state == ST_IDLE);
            r_data_valid <= (w_next_state == ST_RESPOND);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_req_hs) w_next_state = ST_FETCH;
            ST_FETCH:   if (w_last) w_next_state = ST_RESPOND;
            ST_RESPOND: if (DATA_FROM_L2_READY_INS) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Base is block-aligned, so OR-ing in the word offset never carries past the top bit
    always_comb begin
        MEM_READ_VALID          = w_rd_valid;
        MEM_ADDRESS             = w_rd_valid ? (r_base | AW'(r_issue_cnt[IDX_W-1:0])) : '0;
        ADDRESS_TO_L2_READY_INS = r_ready;
        DATA_FROM_L2_VALID_INS  = r_data_valid;
        DATA_FROM_L2_INS        = w_block;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else if (w_req_hs) begin
            r_base      <= ADDRESS_TO_L2_INS & BASE_MASK;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            if (w_rd_hs) r_issue_cnt <= r_issue_cnt + 1'b1;
            if (w_wr)    r_recv_cnt  <= r_recv_cnt + 1'b1;
        end
    end

    block_assembly_register #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (WORD_PER_BLOCK),
        .IDX_W      (IDX_W)
    ) u_block (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_we    (w_wr),
        .i_idx   (r_recv_cnt[IDX_W-1:0]),
        .i_word  (MEM_DATA),
        .o_block (w_block)
    );
endmodule

// File: tb/tb_l2_instruction_responder.sv
// Bench for l2_instruction_responder: vector table, random requests, reset-abort sequence.
module tb_l2_instruction_responder;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int WPB = 16;
    localparam int BW  = WPB * DW;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          ADDRESS_TO_L2_VALID_INS;
    logic          ADDRESS_TO_L2_READY_INS;
    logic [AW-1:0] ADDRESS_TO_L2_INS;
    logic          DATA_FROM_L2_VALID_INS;
    logic          DATA_FROM_L2_READY_INS;
    logic [BW-1:0] DATA_FROM_L2_INS;
    logic          MEM_READ_VALID;
    logic          MEM_READ_READY;
    logic [AW-1:0] MEM_ADDRESS;
    logic          MEM_DATA_VALID;
    logic [DW-1:0] MEM_DATA;

    l2_instruction_responder dut (
        .CLK                     (CLK),
        .RST_N                   (RST_N),
        .ADDRESS_TO_L2_VALID_INS (ADDRESS_TO_L2_VALID_INS),
        .ADDRESS_TO_L2_READY_INS (ADDRESS_TO_L2_READY_INS),
        .ADDRESS_TO_L2_INS       (ADDRESS_TO_L2_INS),
        .DATA_FROM_L2_VALID_INS  (DATA_FROM_L2_VALID_INS),
        .DATA_FROM_L2_READY_INS  (DATA_FROM_L2_READY_INS),
        .DATA_FROM_L2_INS        (DATA_FROM_L2_INS),
        .MEM_READ_VALID          (MEM_READ_VALID),
        .MEM_READ_READY          (MEM_READ_READY),
        .MEM_ADDRESS             (MEM_ADDRESS),
        .MEM_DATA_VALID          (MEM_DATA_VALID),
        .MEM_DATA                (MEM_DATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] base;
        int            rmode;   // 0 always ready, 1 toggling, 2 random
        int            lrand;   // random data-return gaps
        int            rdelay;  // cycles L1 holds READY low
        bit            hold;    // keep request valid with changing address
        bit            lat;     // check exact valid latency
    } vec_t;

    int            total = 0;
    int            bad   = 0;
    logic [AW-1:0] mq[$];       // reads accepted by memory, awaiting data
    logic [AW-1:0] issued[$];   // every read handshake seen this transaction
    int            rdy_mode  = 0;
    int            lat_rand  = 0;
    bit            stale_inj = 1'b0;
    bit            hold_valid = 1'b0;
    bit            tog = 1'b0;
    int            dv_cnt = 0;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [BW-1:0] model_block(input logic [AW-1:0] base);
        logic [BW-1:0] b;
        for (int k = 0; k < WPB; k++) b[k*DW +: DW] = memf(base + AW'(k));
        return b;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock: record handshakes, check stall stability, then drive memory and inputs
    task automatic tick();
        bit            rd_hs, stalled;
        logic [AW-1:0] ra, a;
        rd_hs   = MEM_READ_VALID && MEM_READ_READY;
        stalled = MEM_READ_VALID && !MEM_READ_READY && RST_N;
        ra      = MEM_ADDRESS;
        @(posedge CLK); #1;
        if (rd_hs) begin mq.push_back(ra); issued.push_back(ra); end
        if (stalled) begin
            chk("stall_valid", MEM_READ_VALID, 1);
            chk("stall_addr", MEM_ADDRESS, ra);
        end
        if (stale_inj) begin
            MEM_DATA_VALID = 1'b1; MEM_DATA = $urandom;
        end else if (mq.size() > 0 && (lat_rand == 0 || $urandom_range(0, 1) == 1)) begin
            a = mq.pop_front();
            MEM_DATA_VALID = 1'b1; MEM_DATA = memf(a); dv_cnt++;
        end else begin
            MEM_DATA_VALID = 1'b0; MEM_DATA = $urandom;
        end
        tog = ~tog;
        case (rdy_mode)
            0:       MEM_READ_READY = 1'b1;
            1:       MEM_READ_READY = tog;
            default: MEM_READ_READY = 1'($urandom_range(0, 1));
        endcase
        if (hold_valid) ADDRESS_TO_L2_INS = AW'($urandom);
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && mq.size() > 0; n++) tick();
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int            n;
        logic [BW-1:0] exp_blk, held;
        rdy_mode = v.rmode; lat_rand = v.lrand;
        drain();
        issued.delete();
        ADDRESS_TO_L2_VALID_INS = 1'b1;
        ADDRESS_TO_L2_INS       = v.addr;
        n = 0;
        while (!ADDRESS_TO_L2_READY_INS && n < 50) begin tick(); n++; end
        chk({tag, "_ready_in"}, ADDRESS_TO_L2_READY_INS, 1);
        tick();
        if (v.hold) hold_valid = 1'b1;
        else ADDRESS_TO_L2_VALID_INS = 1'b0;
        n = 1;
        while (!DATA_FROM_L2_VALID_INS && n < 400) begin
            chk({tag, "_busy_ready"}, ADDRESS_TO_L2_READY_INS, 0);
            tick(); n++;
        end
        chk({tag, "_valid"}, DATA_FROM_L2_VALID_INS, 1);
        if (v.lat) chk({tag, "_latency"}, n, 18);
        exp_blk = model_block(v.base);
        chk({tag, "_block"}, DATA_FROM_L2_INS, exp_blk);
        chk({tag, "_nreads"}, issued.size(), WPB);
        for (int k = 0; k < WPB && k < issued.size(); k++)
            chk({tag, "_rdaddr"}, issued[k], v.base + AW'(k));
        held = DATA_FROM_L2_INS;
        for (int i = 0; i < v.rdelay; i++) begin
            tick();
            chk({tag, "_hold_valid"}, DATA_FROM_L2_VALID_INS, 1);
            chk({tag, "_hold_data"}, DATA_FROM_L2_INS, held);
            chk({tag, "_hold_ready"}, ADDRESS_TO_L2_READY_INS, 0);
        end
        DATA_FROM_L2_READY_INS = 1'b1;
        tick();
        DATA_FROM_L2_READY_INS = 1'b0;
        hold_valid = 1'b0;
        chk({tag, "_done_valid"}, DATA_FROM_L2_VALID_INS, 0);
        chk({tag, "_idle_ready"}, ADDRESS_TO_L2_READY_INS, 1);
        chk({tag, "_retain"}, DATA_FROM_L2_INS, exp_blk);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        tbl[0] = '{30'h0000_0013, 30'h0000_0010, 0, 0, 0, 1'b0, 1'b1};
        tbl[1] = '{30'h0000_0100, 30'h0000_0100, 0, 0, 5, 1'b0, 1'b1};
        tbl[2] = '{30'h2345_678A, 30'h2345_6780, 1, 0, 2, 1'b0, 1'b0};
        tbl[3] = '{30'h0ABC_DEF5, 30'h0ABC_DEF0, 0, 0, 1, 1'b1, 1'b1};
        tbl[4] = '{30'h0000_0777, 30'h0000_0770, 0, 0, 0, 1'b0, 1'b1};
        tbl[5] = '{30'h3FFF_FFFF, 30'h3FFF_FFF0, 2, 1, 3, 1'b0, 1'b0};

        RST_N = 1'b0;
        ADDRESS_TO_L2_VALID_INS = 1'b0; ADDRESS_TO_L2_INS = '0;
        DATA_FROM_L2_READY_INS = 1'b0;
        MEM_READ_READY = 1'b1; MEM_DATA_VALID = 1'b0; MEM_DATA = '0;

        for (int i = 0; i < 3; i++) tick();
        chk("rst_ready", ADDRESS_TO_L2_READY_INS, 0);
        chk("rst_dvalid", DATA_FROM_L2_VALID_INS, 0);
        chk("rst_rvalid", MEM_READ_VALID, 0);
        chk("rst_addr", MEM_ADDRESS, 0);
        chk("rst_data", DATA_FROM_L2_INS, 0);
        RST_N = 1'b1;
        tick();
        chk("rst_release_ready", ADDRESS_TO_L2_READY_INS, 1);

        for (int i = 0; i < 6; i++) do_req(tbl[i], $sformatf("vec%0d", i));

        // Reset mid-FETCH after 7 words captured, then stale data pulses
        rdy_mode = 0; lat_rand = 0;
        drain();
        ADDRESS_TO_L2_VALID_INS = 1'b1; ADDRESS_TO_L2_INS = 30'h0000_0055;
        tick();
        ADDRESS_TO_L2_VALID_INS = 1'b0;
        dv_cnt = 0;
        for (int n = 0; n < 50 && dv_cnt < 7; n++) tick();
        chk("abort_progress", dv_cnt, 7);
        tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("abort_ready", ADDRESS_TO_L2_READY_INS, 0);
        chk("abort_dvalid", DATA_FROM_L2_VALID_INS, 0);
        chk("abort_rvalid", MEM_READ_VALID, 0);
        chk("abort_addr", MEM_ADDRESS, 0);
        chk("abort_data", DATA_FROM_L2_INS, 0);
        stale_inj = 1'b1;
        tick();
        chk("abort_release_ready", ADDRESS_TO_L2_READY_INS, 1);
        tick(); tick();
        stale_inj = 1'b0;
        drain();
        tick();
        chk("stale_data", DATA_FROM_L2_INS, 0);
        chk("stale_rvalid", MEM_READ_VALID, 0);
        chk("stale_ready", ADDRESS_TO_L2_READY_INS, 1);
        rv = '{30'h0000_0055, 30'h0000_0050, 0, 0, 1, 1'b0, 1'b1};
        do_req(rv, "after_abort");

        for (int i = 0; i < 5; i++) begin
            rv.addr   = AW'($urandom);
            rv.base   = rv.addr & ~AW'(WPB - 1);
            rv.rmode  = $urandom_range(0, 2);
            rv.lrand  = $urandom_range(0, 1);
            rv.rdelay = $urandom_range(0, 3);
            rv.hold   = 1'($urandom_range(0, 1));
            rv.lat    = (rv.rmode == 0 && rv.lrand == 0);
            do_req(rv, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
